// File: rtl/dmem_lsu_pkg.sv
// Shared types and helpers for the dmem load/store unit: access sizes, FSM states,
// byte-lane masks and boundary-crossing detection for 8-byte beats.
package lsu_pkg;

    localparam int BEAT_BYTES = 8;
    localparam int BEAT_SHIFT = 3;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2,
        RESP  = 2'd3
    } state_e;

    function automatic logic [7:0] byte_mask(input size_e size);
        logic [7:0] mask;
        case (size)
            SIZE_B:  mask = 8'h01;
            SIZE_H:  mask = 8'h03;
            SIZE_W:  mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

    function automatic logic [63:0] bits_from_bytes(input logic [7:0] mask8);
        logic [63:0] bits;
        bits = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            bits[i*8 +: 8] = {8{mask8[i]}};
        end
        return bits;
    endfunction

    function automatic logic crosses(input logic [2:0] off, input size_e size);
        logic [3:0] nbytes;
        nbytes = 4'd1 << size;
        return ({1'b0, off} + nbytes) > 4'd8;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Bundle of the pipeline request/response handshake and the RAM data-port signals.
// The LSU takes the slave view; the pipeline/RAM side takes the master view.
interface dmem_lsu_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              dmem_en;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_rdata;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_wmask;
    logic              dmem_wen;

    modport slave (
        input  req_valid, req_wen, req_addr, req_size, req_signed, req_wdata, dmem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output dmem_en, dmem_addr, dmem_wdata, dmem_wmask, dmem_wen
    );

    modport master (
        output req_valid, req_wen, req_addr, req_size, req_signed, req_wdata, dmem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  dmem_en, dmem_addr, dmem_wdata, dmem_wmask, dmem_wen
    );
endinterface

// File: rtl/dmem_lsu_align.sv
// Combinational lane steering: per-beat write data/mask shifting and the two-beat
// read merge followed by truncation and sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        second_beat,
    input  logic [2:0]  off,
    input  size_e       size,
    input  logic        is_signed,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata_lo,
    input  logic [63:0] rdata_hi,
    output logic [63:0] lane_wdata,
    output logic [63:0] lane_wmask,
    output logic [63:0] load_data
);
    logic [5:0]  sh_bits;
    logic [6:0]  inv_bits;
    logic [15:0] mask16;
    logic [63:0] merged;
    logic [63:0] ext [3];

    assign sh_bits  = {off, 3'b000};
    assign inv_bits = 7'd64 - {1'b0, sh_bits};
    // Upper byte of mask16 holds the lanes that spill into the next beat.
    assign mask16   = {8'h00, byte_mask(size)} << off;

    assign lane_wdata = second_beat ? (wdata >> inv_bits) : (wdata << sh_bits);
    assign lane_wmask = second_beat ? bits_from_bytes(mask16[15:8])
                                    : bits_from_bytes(mask16[7:0]);

    // A 64-bit shift by 64 yields zero, so off=0 needs no special case.
    assign merged = (rdata_lo >> sh_bits) | (rdata_hi << inv_bits);

    for (genvar gi = 0; gi < 3; gi++) begin : g_ext
        localparam int W = 8 << gi;
        assign ext[gi] = {{(64-W){is_signed & merged[W-1]}}, merged[W-1:0]};
    end

    always_comb begin
        load_data = merged;
        case (size)
            SIZE_B:  load_data = ext[0];
            SIZE_H:  load_data = ext[1];
            SIZE_W:  load_data = ext[2];
            default: load_data = merged;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of the RAM data port: one request at a time, 1 or 2 beats.
// LSU_MISALIGN_SPLIT_EN: defined = split 8-byte-crossing accesses, undefined = flag them via resp_err.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic     clk,
    input  logic     rst_n,
    dmem_lsu_if.slave bus
);
    if (DATA_W != 64) begin : g_width_check
        $error("dmem_lsu supports DATA_W=64 only");
    end

    state_e            state_reg, state_next;
    logic              wen_reg, signed_reg, cross_reg;
    logic [ADDR_W-1:0] addr_reg;
    size_e             size_reg;
    logic [63:0]       wdata_reg, beat1_reg;
    logic [63:0]       resp_rdata_reg;
    logic              resp_err_reg;

    logic              accept;
    logic              beat_live;
    logic              split_ok;
    logic [ADDR_W-1:0] beat_addr;
    logic [63:0]       lane_wdata, lane_wmask, load_data;
    logic [63:0]       rdata_lo, rdata_hi;

    assign bus.req_ready = (state_reg == IDLE) & rst_n;
    assign accept        = bus.req_valid & bus.req_ready;

`ifdef LSU_MISALIGN_SPLIT_EN
    assign split_ok = 1'b1;
`else
    assign split_ok = ~cross_reg;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = BEAT1;
            BEAT1:   state_next = (cross_reg && split_ok) ? BEAT2 : RESP;
            BEAT2:   state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    // A crossing request without splitting support is held off the RAM entirely.
    assign beat_live = (state_reg == BEAT2) || ((state_reg == BEAT1) && split_ok);
    assign beat_addr = {addr_reg[ADDR_W-1:BEAT_SHIFT], {BEAT_SHIFT{1'b0}}}
                     + ((state_reg == BEAT2) ? ADDR_W'(BEAT_BYTES) : '0);

    always_comb begin
        bus.dmem_en    = 1'b0;
        bus.dmem_wen   = 1'b0;
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;
        bus.dmem_wmask = '0;
        if (beat_live) begin
            bus.dmem_en    = 1'b1;
            bus.dmem_wen   = wen_reg;
            bus.dmem_addr  = beat_addr;
            bus.dmem_wdata = lane_wdata;
            bus.dmem_wmask = lane_wmask;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wen_reg    <= 1'b0;
            signed_reg <= 1'b0;
            cross_reg  <= 1'b0;
            addr_reg   <= '0;
            size_reg   <= SIZE_B;
            wdata_reg  <= '0;
            beat1_reg  <= '0;
        end else begin
            if (accept) begin
                wen_reg    <= bus.req_wen;
                signed_reg <= bus.req_signed;
                addr_reg   <= bus.req_addr;
                size_reg   <= size_e'(bus.req_size);
                wdata_reg  <= bus.req_wdata;
                cross_reg  <= crosses(bus.req_addr[2:0], size_e'(bus.req_size));
            end
            if (state_reg == BEAT1) begin
                beat1_reg <= bus.dmem_rdata;
            end
        end
    end

    // In BEAT2 the first beat comes from the capture register, the second is live.
    assign rdata_lo = (state_reg == BEAT2) ? beat1_reg : bus.dmem_rdata;
    assign rdata_hi = (state_reg == BEAT2) ? bus.dmem_rdata : '0;

    lsu_align u_align (
        .second_beat (state_reg == BEAT2),
        .off         (addr_reg[2:0]),
        .size        (size_reg),
        .is_signed   (signed_reg && (size_reg != SIZE_D)),
        .wdata       (wdata_reg),
        .rdata_lo    (rdata_lo),
        .rdata_hi    (rdata_hi),
        .lane_wdata  (lane_wdata),
        .lane_wmask  (lane_wmask),
        .load_data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
        end else if ((state_reg == BEAT2) || ((state_reg == BEAT1) && !cross_reg)) begin
            resp_rdata_reg <= wen_reg ? 64'd0 : load_data;
            resp_err_reg   <= 1'b0;
        end else if (state_reg == BEAT1 && !split_ok) begin
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b1;
        end
    end

    always_comb begin
        bus.resp_valid = (state_reg == RESP);
        bus.resp_rdata = resp_rdata_reg;
        bus.resp_err   = resp_err_reg;
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu with a small behavioural RAM on the data port.
// Covers both builds of LSU_MISALIGN_SPLIT_EN.
module tb_dmem_lsu;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    dmem_lsu_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    dmem_lsu #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // 16 x 64-bit RAM covering 0x8000_0000..0x8000_007F, combinational read.
    logic [63:0] mem [16];
    logic [3:0]  ram_idx;
    assign ram_idx = bus.dmem_addr[6:3];
    always_comb bus.dmem_rdata = mem[ram_idx];
    always @(posedge clk) begin
        if (bus.dmem_en && bus.dmem_wen)
            mem[ram_idx] <= (mem[ram_idx] & ~bus.dmem_wmask) | (bus.dmem_wdata & bus.dmem_wmask);
    end

    int          n_beats;
    int          lat;
    logic [63:0] b_addr [2];
    logic [63:0] b_wdata [2];
    logic [63:0] b_wmask [2];
    logic [63:0] r_rdata;
    logic        r_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic wen, input logic [63:0] addr,
                          input logic [1:0] size, input logic sgn, input logic [63:0] wdata,
                          input int exp_lat);
        @(negedge clk);
        check({tag, "_ready"}, {63'd0, bus.req_ready}, 64'd1);
        bus.req_valid  = 1'b1;
        bus.req_wen    = wen;
        bus.req_addr   = addr;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_wdata  = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_wdata = 64'hA5A5_A5A5_A5A5_A5A5;
        n_beats = 0;
        lat     = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (bus.dmem_en) begin
                if (n_beats < 2) begin
                    b_addr[n_beats]  = bus.dmem_addr;
                    b_wdata[n_beats] = bus.dmem_wdata;
                    b_wmask[n_beats] = bus.dmem_wmask;
                end
                n_beats++;
            end
            if (bus.resp_valid) begin
                lat     = k;
                r_rdata = bus.resp_rdata;
                r_err   = bus.resp_err;
            end
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        $display("txn %-6s wen=%0d addr=0x%016h size=%0d beats=%0d lat=%0d rdata=0x%016h err=%0d",
                 tag, wen, addr, size, n_beats, lat, r_rdata, r_err);
    endtask

    int acc_cnt, resp_cnt, first_acc, second_acc, en_cnt;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 64'd0;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_wen    = 1'b0;
        bus.req_addr   = 64'd0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_wdata  = 64'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {63'd0, bus.resp_valid}, 64'd0);
        check("rst_rdata", bus.resp_rdata, 64'd0);
        check("rst_err",   {63'd0, bus.resp_err}, 64'd0);
        check("rst_en",    {63'd0, bus.dmem_en}, 64'd0);
        check("rst_wmask", bus.dmem_wmask, 64'd0);
        check("rst_ready", {63'd0, bus.req_ready}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_ready_rel", {63'd0, bus.req_ready}, 64'd1);

        // Aligned double store then load back.
        do_req("SD", 1'b1, 64'h8000_0010, 2'd3, 1'b0, 64'h1122_3344_5566_7788, 2);
        check("SD_beats", 64'(n_beats), 64'd1);
        check("SD_addr",  b_addr[0],  64'h8000_0010);
        check("SD_wmask", b_wmask[0], 64'hFFFF_FFFF_FFFF_FFFF);
        check("SD_wdata", b_wdata[0], 64'h1122_3344_5566_7788);
        check("SD_rdata", r_rdata, 64'd0);
        do_req("LD", 1'b0, 64'h8000_0010, 2'd3, 1'b1, 64'd0, 2);
        check("LD_rdata", r_rdata, 64'h1122_3344_5566_7788);
        check("LD_err",   {63'd0, r_err}, 64'd0);

        // Byte store of 0x80 at offset 3, then signed and unsigned byte loads.
        do_req("SB", 1'b1, 64'h8000_0013, 2'd0, 1'b0, 64'h80, 2);
        check("SB_wmask", b_wmask[0], 64'h0000_0000_FF00_0000);
        check("SB_wdata", b_wdata[0], 64'h0000_0000_8000_0000);
        do_req("LB", 1'b0, 64'h8000_0013, 2'd0, 1'b1, 64'd0, 2);
        check("LB_rdata", r_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        do_req("LBU", 1'b0, 64'h8000_0013, 2'd0, 1'b0, 64'd0, 2);
        check("LBU_rdata", r_rdata, 64'h0000_0000_0000_0080);

        // Halfword store into the top lanes of a beat.
        do_req("SH", 1'b1, 64'h8000_0006, 2'd1, 1'b0, 64'hBEEF, 2);
        check("SH_addr",  b_addr[0],  64'h8000_0000);
        check("SH_wmask", b_wmask[0], 64'hFFFF_0000_0000_0000);
        check("SH_wdata", {48'd0, b_wdata[0][63:48]}, 64'hBEEF);
        do_req("LHU", 1'b0, 64'h8000_0006, 2'd1, 1'b0, 64'd0, 2);
        check("LHU_rdata", r_rdata, 64'h0000_0000_0000_BEEF);
        do_req("LH", 1'b0, 64'h8000_0006, 2'd1, 1'b1, 64'd0, 2);
        check("LH_rdata", r_rdata, 64'hFFFF_FFFF_FFFF_BEEF);
        // Word ending exactly on the beat boundary does not cross.
        do_req("LW4", 1'b0, 64'h8000_0004, 2'd2, 1'b1, 64'd0, 2);
        check("LW4_beats", 64'(n_beats), 64'd1);
        check("LW4_rdata", r_rdata, 64'hFFFF_FFFF_BEEF_0000);

`ifdef LSU_MISALIGN_SPLIT_EN
        do_req("SWX", 1'b1, 64'h8000_0006, 2'd2, 1'b0, 64'hDEAD_BEEF, 3);
        check("SWX_beats",  64'(n_beats), 64'd2);
        check("SWX_addr1",  b_addr[0],  64'h8000_0000);
        check("SWX_wmask1", b_wmask[0], 64'hFFFF_0000_0000_0000);
        check("SWX_wdata1", b_wdata[0], 64'hBEEF_0000_0000_0000);
        check("SWX_addr2",  b_addr[1],  64'h8000_0008);
        check("SWX_wmask2", b_wmask[1], 64'h0000_0000_0000_FFFF);
        check("SWX_wdata2", b_wdata[1], 64'h0000_0000_0000_DEAD);
        check("SWX_err",    {63'd0, r_err}, 64'd0);
        do_req("LWX", 1'b0, 64'h8000_0006, 2'd2, 1'b1, 64'd0, 3);
        check("LWX_beats", 64'(n_beats), 64'd2);
        check("LWX_rdata", r_rdata, 64'hFFFF_FFFF_DEAD_BEEF);
        check("LWX_err",   {63'd0, r_err}, 64'd0);
`else
        do_req("LDX", 1'b0, 64'h8000_0004, 2'd3, 1'b0, 64'd0, 2);
        check("LDX_beats", 64'(n_beats), 64'd0);
        check("LDX_err",   {63'd0, r_err}, 64'd1);
        check("LDX_rdata", r_rdata, 64'd0);
        do_req("SWX", 1'b1, 64'h8000_0006, 2'd2, 1'b0, 64'hDEAD_BEEF, 2);
        check("SWX_beats", 64'(n_beats), 64'd0);
        check("SWX_err",   {63'd0, r_err}, 64'd1);
        do_req("LD0", 1'b0, 64'h8000_0000, 2'd3, 1'b0, 64'd0, 2);
        check("LD0_rdata", r_rdata, 64'hBEEF_0000_0000_0000);
        check("LD0_err",   {63'd0, r_err}, 64'd0);
`endif

        // Reset asserted while a store is in BEAT1: no response may follow.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_wen    = 1'b1;
        bus.req_addr   = 64'h8000_0020;
        bus.req_size   = 2'd3;
        bus.req_wdata  = 64'h0123_4567_89AB_CDEF;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst_n         = 1'b0;
        resp_cnt = 0;
        en_cnt   = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.resp_valid) resp_cnt++;
        end
        check("mid_rst_ready", {63'd0, bus.req_ready}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", {63'd0, bus.req_ready}, 64'd1);
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid) resp_cnt++;
            if (bus.dmem_en) en_cnt++;
        end
        check("mid_rst_resp", 64'(resp_cnt), 64'd0);
        check("mid_rst_en",   64'(en_cnt), 64'd0);
        $display("txn RSTMID resp_pulses=%0d beats_after=%0d", resp_cnt, en_cnt);

        // Back-to-back aligned loads with valid held high.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_wen    = 1'b0;
        bus.req_addr   = 64'h8000_0010;
        bus.req_size   = 2'd3;
        bus.req_signed = 1'b0;
        acc_cnt    = 0;
        resp_cnt   = 0;
        first_acc  = -1;
        second_acc = -1;
        for (int c = 0; c < 9; c++) begin
            if (bus.req_ready) begin
                if (acc_cnt == 0) first_acc = c;
                if (acc_cnt == 1) second_acc = c;
                acc_cnt++;
            end
            if (bus.resp_valid) resp_cnt++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        check("b2b_accepts", 64'(acc_cnt), 64'd3);
        check("b2b_resps",   64'(resp_cnt), 64'd3);
        check("b2b_interval", 64'(second_acc - first_acc), 64'd3);
        $display("txn B2B accepts=%0d resps=%0d interval=%0d", acc_cnt, resp_cnt, second_acc - first_acc);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit that sits directly upstream of the 2-read/1-write DPI RAM model's data port.
- Accepts one byte/half/word/double request at a time from the MEM stage over a valid/ready handshake.
- Drives the RAM data-port signals `dmem_en`, `dmem_addr`, `dmem_wdata`, `dmem_wmask` (64-bit bit-mask) and `dmem_wen`, and consumes `dmem_rdata`.
- Returns aligned, sign/zero-extended load data, or a store-completion pulse, to the pipeline.

Parameters:
- ADDR_W, 64, request/memory address width.
- DATA_W, 64, data width; only 64 is supported (elaboration error otherwise).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  0=B, 1=H, 2=W, 3=D.
- req_signed  in  1  sign-extend load result.
- req_wdata  in  DATA_W  store data, LSB-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  extended load data; 0 for stores.
- resp_err  out  1  misaligned-access error (see Optional Feature).
- dmem_en  out  1  RAM access enable.
- dmem_addr  out  ADDR_W  8-byte-aligned beat address.
- dmem_rdata  in  DATA_W  combinational RAM read data.
- dmem_wdata  out  DATA_W  lane-shifted write data.
- dmem_wmask  out  DATA_W  bit-granular write mask.
- dmem_wen  out  1  write enable (qualified by `dmem_en` inside the RAM).

Behaviour:
- FSM states: IDLE, BEAT1, BEAT2, RESP.
  - IDLE -> BEAT1 on `req_valid & req_ready`.
  - BEAT1 -> BEAT2 if the access crosses an 8-byte boundary, else BEAT1 -> RESP.
  - BEAT2 -> RESP.
  - RESP -> IDLE.
- `req_ready` = (state==IDLE) & rst_n.
- The request is registered on acceptance; the `req_*` inputs are don't-care afterwards.
- Definitions: off = addr[2:0]; nbytes = 1<<size; cross = off + nbytes > 8.
- BEAT1 outputs:
  - `dmem_en`=1, `dmem_addr`={addr[63:3],3'b0}, `dmem_wen`=wen.
  - `dmem_wdata` = wdata << 8*off.
  - `dmem_wmask` = byte mask of nbytes, shifted by off, expanded to bits.
- BEAT2 outputs:
  - `dmem_addr` = beat1 address + 8.
  - `dmem_wdata` = wdata >> 8*(8-off).
  - `dmem_wmask` = bytes that overflowed beat1, at lanes 0...
- Load capture: `dmem_rdata` is captured at the end of each beat.
  - Result = (beat1 >> 8*off) | (beat2 << 8*(8-off)), truncated to nbytes.
  - Then sign- or zero-extended per `req_signed` (`req_signed` is ignored for D).
- Outputs in IDLE and RESP: `dmem_en`, `dmem_wen`, `dmem_wdata` and `dmem_wmask` are all 0.
- Latency: accept at edge T.
  - Non-crossing: beat in cycle T+1, `resp_valid` in T+2.
  - Crossing: beats in T+1 and T+2, `resp_valid` in T+3.
- Response registers: `resp_valid` is high only in RESP, with no backpressure. `resp_rdata` holds its value until the next RESP.
- Reset values: state=IDLE; `resp_valid`=0, `resp_rdata`=0, `resp_err`=0; all `dmem_*` outputs 0.
- Reset mid-op: state returns to IDLE at the edge and no response is issued. For a crossing store reset during BEAT2, the beat1 write has already committed; this partial write is accepted.
- Address arithmetic:
  - Beat2 address wraps modulo 2^ADDR_W.
  - No base subtraction here; the RAM model subtracts 0x8000_0000.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: crossing accesses are split into two beats as above; `resp_err` is always 0.
- Undefined: a crossing request takes IDLE -> BEAT1 -> RESP with `dmem_en`=0 in BEAT1. No memory access occurs. `resp_valid`=1, `resp_err`=1, `resp_rdata`=0 in T+2. BEAT2 is unreachable.

Decomposition:
- Package `lsu_pkg`:
  - `size_e` (B/H/W/D) and `state_e`.
  - Constants `BEAT_BYTES`=8 and `BEAT_SHIFT`=3.
  - Functions `byte_mask(size)`, `bits_from_bytes(mask8)` and `crosses(off,size)`.
- Sub-module `lsu_align` (combinational): lane shift for wdata/wmask per beat, read merge and sign-extension; the FSM stays in `dmem_lsu`.

Test Plan:
- Aligned SD to 0x8000_0010, wdata 0x1122334455667788, then LD: `dmem_wmask`=all-ones in the store beat; load returns 0x1122334455667788 at T+2.
- LB signed at 0x8000_0013 with memory word 0x..._80_..., byte 0x80: `resp_rdata`=0xFFFFFFFFFFFFFF80. LBU at the same address returns 0x80.
- SH 0xBEEF at 0x8000_0006: `dmem_wmask`=0xFFFF_0000_0000_0000; `dmem_wdata`[63:48]=0xBEEF.
- With the macro defined, SW 0xDEADBEEF at 0x8000_0006:
  - beat1 at 0x8000_0000 with mask 0xFFFF<<48, data 0xBEEF<<48;
  - beat2 at 0x8000_0008 with mask 0xFFFF, data 0xDEAD;
  - then LW returns 0xFFFFFFFFDEADBEEF (signed); `resp_valid` at T+3.
- With the macro undefined, LD at 0x8000_0004: `dmem_en` never asserted; `resp_err`=1, `resp_valid` at T+2.
- Reset asserted in BEAT1 of a store: no `resp_valid`; `req_ready`=1 in the first cycle after `rst_n` deasserts; back-to-back requests are accepted every 3 cycles when aligned.
